// File: rtl/axi_lite_master_bridge_if.sv
// Bundle of request/response and AXI-Lite channel signals for the master bridge.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface axi_lite_master_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // Core-side request/response
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // AXI-Lite read channels
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    // AXI-Lite write channels
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output araddr, arvalid, rready,
        input  arready, rdata, rresp, rvalid,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  araddr, arvalid, rready,
        output arready, rdata, rresp, rvalid,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// Single-outstanding AXI-Lite initiator: turns one core load/store request into
// an AR/R or AW/W/B transaction and returns the result on a valid/ready response.
module axi_lite_master_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    axi_lite_master_bridge_if.master bus
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_REQ  = 3'd3,
        WR_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;
    logic              aw_done;
    logic              w_done;

    logic              accept;
    logic              aw_hs;
    logic              w_hs;
    logic              r_capture;
    logic              b_capture;

    // NOTE: rst is folded in combinationally so req_ready is low for the whole
    // time rst is asserted, not just from the first clock edge after it.
    assign bus.req_ready = (state == IDLE) && !rst;
    assign accept        = bus.req_valid && (state == IDLE) && !rst;

    // AXI address/data outputs come only from the captured request registers,
    // so they stay stable while the requester changes its inputs.
    assign bus.araddr    = addr_q;
    assign bus.awaddr    = addr_q;
    assign bus.wdata     = wdata_q;
    assign bus.wstrb     = wstrb_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first; a missing default
    // on any path would infer a latch.
    always_comb begin
        state_next  = state;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        bus.rsp_valid = 1'b0;
        aw_hs       = 1'b0;
        w_hs        = 1'b0;
        r_capture   = 1'b0;
        b_capture   = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = bus.req_wen ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                bus.arvalid = 1'b1;
                if (bus.arready) begin
                    state_next = RD_DATA;
                end
            end
            RD_DATA: begin
                bus.rready = 1'b1;
                if (bus.rvalid) begin
                    r_capture  = 1'b1;
                    state_next = RSP;
                end
            end
            WR_REQ: begin
                bus.awvalid = !aw_done;
                bus.wvalid  = !w_done;
                aw_hs       = !aw_done && bus.awready;
                w_hs        = !w_done && bus.wready;
                // The completing handshake counts in the same cycle it happens.
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_next = WR_RESP;
                end
            end
            WR_RESP: begin
                bus.bready = 1'b1;
                if (bus.bvalid) begin
                    b_capture  = 1'b1;
                    state_next = RSP;
                end
            end
            RSP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wstrb_q <= bus.req_wstrb;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
            if (r_capture) begin
                rsp_rdata_q <= bus.rdata;
                rsp_err_q   <= (bus.rresp != 2'b00);
            end
            if (b_capture) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= (bus.bresp != 2'b00);
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: directed cycle-exact scenarios followed by
// randomized transactions with a protocol-level slave and expected-response model.
module tb_axi_lite_master_bridge;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    axi_lite_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_master_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle, then scramble the request fields
    // so that any late use of them by the bridge shows up.
    task automatic issue(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws);
        check("issue_req_ready", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_wstrb = 4'($urandom_range(0, 15));
    endtask

    // Read with an always-ready slave: accept T, AR T+1, R T+2, response T+3.
    task automatic do_read_fast(input string tag, input logic [31:0] a,
                                input logic [31:0] d, input logic [1:0] r);
        issue(1'b0, a, 32'h0, 4'h0);
        check({tag, "_arvalid_t1"}, bus.arvalid, 1);
        check({tag, "_araddr_t1"}, bus.araddr, a);
        check({tag, "_rready_t1"}, bus.rready, 0);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check({tag, "_arvalid_t2"}, bus.arvalid, 0);
        check({tag, "_rready_t2"}, bus.rready, 1);
        check({tag, "_rsp_valid_t2"}, bus.rsp_valid, 0);
        bus.rvalid = 1'b1;
        bus.rdata  = d;
        bus.rresp  = r;
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = $urandom;
        check({tag, "_rsp_valid_t3"}, bus.rsp_valid, 1);
        check({tag, "_rsp_rdata_t3"}, bus.rsp_rdata, d);
        check({tag, "_rsp_err_t3"}, bus.rsp_err, (r != 2'b00));
        check({tag, "_req_ready_t3"}, bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check({tag, "_rsp_valid_t4"}, bus.rsp_valid, 0);
        check({tag, "_req_ready_t4"}, bus.req_ready, 1);
    endtask

    logic        wen;
    logic [31:0] ra;
    logic [31:0] rwd;
    logic [31:0] rrd;
    logic [3:0]  rws;
    logic [1:0]  rrs;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        ar_seen, aw_seen, w_seen, x_done, done;
    logic        ar_pend, aw_pend, w_pend;
    logic        ar_hs, aw_hs, w_hs;

    initial begin
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b0;
        bus.arready   = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = '0;
        bus.rvalid    = 1'b0;
        bus.awready   = 1'b0;
        bus.wready    = 1'b0;
        bus.bresp     = '0;
        bus.bvalid    = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready,
                             bus.bready, bus.rsp_valid, bus.rsp_err}, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_addrs", {bus.araddr, bus.awaddr}, 0);
        check("rst_wdata", {bus.wdata, bus.wstrb}, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", bus.req_ready, 1);

        // 1: read with always-ready slave
        do_read_fast("t1", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00);

        // 2: write, AW at T+1, W delayed to T+4, B at T+5
        issue(1'b1, 32'hA000_03F8, 32'h0000_0041, 4'b0001);
        check("t2_awvalid_t1", bus.awvalid, 1);
        check("t2_wvalid_t1", bus.wvalid, 1);
        check("t2_awaddr_t1", bus.awaddr, 32'hA000_03F8);
        check("t2_wdata_t1", bus.wdata, 32'h41);
        check("t2_wstrb_t1", bus.wstrb, 4'b0001);
        bus.awready = 1'b1;
        tick();
        bus.awready = 1'b0;
        check("t2_awvalid_t2", bus.awvalid, 0);
        check("t2_wvalid_t2", bus.wvalid, 1);
        check("t2_bready_t2", bus.bready, 0);
        tick();
        check("t2_wvalid_t3", bus.wvalid, 1);
        check("t2_wdata_t3", bus.wdata, 32'h41);
        check("t2_bready_t3", bus.bready, 0);
        tick();
        check("t2_wvalid_t4", bus.wvalid, 1);
        check("t2_bready_t4", bus.bready, 0);
        bus.wready = 1'b1;
        tick();
        bus.wready = 1'b0;
        check("t2_wvalid_t5", bus.wvalid, 0);
        check("t2_bready_t5", bus.bready, 1);
        bus.bvalid = 1'b1;
        bus.bresp  = 2'b00;
        tick();
        bus.bvalid = 1'b0;
        check("t2_rsp_valid_t6", bus.rsp_valid, 1);
        check("t2_rsp_rdata_t6", bus.rsp_rdata, 0);
        check("t2_rsp_err_t6", bus.rsp_err, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // 3: W completes first, AW held stable, error response
        issue(1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1111);
        check("t3_awvalid_t1", bus.awvalid, 1);
        check("t3_wvalid_t1", bus.wvalid, 1);
        bus.wready = 1'b1;
        tick();
        bus.wready = 1'b0;
        check("t3_wvalid_t2", bus.wvalid, 0);
        check("t3_awvalid_t2", bus.awvalid, 1);
        check("t3_awaddr_t2", bus.awaddr, 32'h0000_1000);
        check("t3_bready_t2", bus.bready, 0);
        tick();
        check("t3_awvalid_t3", bus.awvalid, 1);
        check("t3_awaddr_t3", bus.awaddr, 32'h0000_1000);
        check("t3_bready_t3", bus.bready, 0);
        bus.awready = 1'b1;
        tick();
        bus.awready = 1'b0;
        check("t3_awvalid_t4", bus.awvalid, 0);
        check("t3_bready_t4", bus.bready, 1);
        bus.bvalid = 1'b1;
        bus.bresp  = 2'b10;
        tick();
        bus.bvalid = 1'b0;
        bus.bresp  = 2'b00;
        check("t3_rsp_valid", bus.rsp_valid, 1);
        check("t3_rsp_err", bus.rsp_err, 1);
        check("t3_rsp_rdata", bus.rsp_rdata, 0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;

        // 4: read with arready stalled 5 cycles, SLVERR/DECERR response
        issue(1'b0, 32'h1234_5670, 32'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            check("t4_arvalid_stall", bus.arvalid, 1);
            check("t4_araddr_stall", bus.araddr, 32'h1234_5670);
            check("t4_rready_stall", bus.rready, 0);
            tick();
        end
        check("t4_arvalid_hs", bus.arvalid, 1);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check("t4_arvalid_after", bus.arvalid, 0);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hCAFE_F00D;
        bus.rresp  = 2'b11;
        tick();
        bus.rvalid = 1'b0;
        bus.rdata  = 32'h0BAD_0BAD;
        bus.rresp  = 2'b00;

        // 5: response back-pressure, no accept until the cycle after rsp_ready
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t5_rsp_valid_hold", bus.rsp_valid, 1);
            check("t5_rsp_rdata_hold", bus.rsp_rdata, 32'hCAFE_F00D);
            check("t5_rsp_err_hold", bus.rsp_err, 1);
            check("t5_req_ready_hold", bus.req_ready, 0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        check("t5_req_ready_rsp_cycle", bus.req_ready, 0);
        tick();
        bus.rsp_ready = 1'b0;
        check("t5_rsp_valid_after", bus.rsp_valid, 0);
        check("t5_req_ready_after", bus.req_ready, 1);

        // 6: reset in the middle of a write, late bvalid ignored, then a new read
        issue(1'b1, 32'h5555_0004, 32'hFFFF_0000, 4'b1100);
        check("t6_awvalid_pre", bus.awvalid, 1);
        check("t6_wvalid_pre", bus.wvalid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_awvalid_async", bus.awvalid, 0);
        check("t6_wvalid_async", bus.wvalid, 0);
        check("t6_req_ready_in_rst", bus.req_ready, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("t6_req_ready_release", bus.req_ready, 1);
        bus.bvalid = 1'b1;
        bus.rvalid = 1'b1;
        tick();
        bus.bvalid = 1'b0;
        bus.rvalid = 1'b0;
        check("t6_late_resp_ignored", {bus.bready, bus.rready, bus.rsp_valid}, 0);
        check("t6_idle_after_late", bus.req_ready, 1);
        do_read_fast("t6_read", 32'h8000_0020, 32'h0102_0304, 2'b00);

        // Randomized transactions against a transaction-level expectation
        for (int n = 0; n < 60; n++) begin
            wen = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rwd = $urandom;
            rws = 4'($urandom_range(0, 15));
            rrd = $urandom;
            rrs = 2'($urandom_range(0, 3));
            exp_rdata = wen ? 32'h0 : rrd;
            exp_err   = (rrs != 2'b00);
            issue(wen, ra, rwd, rws);
            ar_seen = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
            x_done  = 1'b0; done    = 1'b0;
            ar_pend = 1'b0; aw_pend = 1'b0; w_pend = 1'b0;
            for (int c = 0; c < 300 && !done; c++) begin
                if (ar_pend) check("rnd_arvalid_held", bus.arvalid, 1);
                if (aw_pend) check("rnd_awvalid_held", bus.awvalid, 1);
                if (w_pend)  check("rnd_wvalid_held", bus.wvalid, 1);
                check("rnd_wrong_channel",
                      wen ? {bus.arvalid, bus.rready} : {bus.awvalid, bus.wvalid, bus.bready}, 0);
                if (bus.arvalid) check("rnd_araddr", bus.araddr, ra);
                if (bus.awvalid) check("rnd_awaddr", bus.awaddr, ra);
                if (bus.wvalid) begin
                    check("rnd_wdata", bus.wdata, rwd);
                    check("rnd_wstrb", bus.wstrb, rws);
                end
                if (bus.bready) check("rnd_bready_early", aw_seen && w_seen, 1);
                if (bus.rsp_valid) begin
                    check("rnd_rsp_rdata", bus.rsp_rdata, exp_rdata);
                    check("rnd_rsp_err", bus.rsp_err, exp_err);
                end

                bus.arready   = 1'($urandom_range(0, 1));
                bus.awready   = 1'($urandom_range(0, 1));
                bus.wready    = 1'($urandom_range(0, 1));
                bus.rvalid    = ar_seen && !x_done && ($urandom_range(0, 2) == 0);
                bus.rdata     = bus.rvalid ? rrd : $urandom;
                bus.rresp     = bus.rvalid ? rrs : 2'($urandom_range(0, 3));
                bus.bvalid    = aw_seen && w_seen && !x_done && ($urandom_range(0, 2) == 0);
                bus.bresp     = bus.bvalid ? rrs : 2'($urandom_range(0, 3));
                bus.rsp_ready = bus.rsp_valid && ($urandom_range(0, 1) == 1);

                ar_hs   = bus.arvalid && bus.arready;
                aw_hs   = bus.awvalid && bus.awready;
                w_hs    = bus.wvalid && bus.wready;
                ar_pend = bus.arvalid && !bus.arready;
                aw_pend = bus.awvalid && !bus.awready;
                w_pend  = bus.wvalid && !bus.wready;
                if ((bus.rvalid && bus.rready) || (bus.bvalid && bus.bready)) x_done = 1'b1;
                if (bus.rsp_valid && bus.rsp_ready) done = 1'b1;
                tick();
                if (ar_hs) ar_seen = 1'b1;
                if (aw_hs) aw_seen = 1'b1;
                if (w_hs)  w_seen  = 1'b1;
            end
            bus.arready   = 1'b0;
            bus.awready   = 1'b0;
            bus.wready    = 1'b0;
            bus.rvalid    = 1'b0;
            bus.bvalid    = 1'b0;
            bus.rsp_ready = 1'b0;
            check("rnd_timeout", done, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
